button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 129 ++++++++++++
 tb/tb_button_conditioner.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Pushbutton front end: per-channel two-flop synchroniser, counter debounce,
// registered press/release strobes and an auto-repeat step strobe for held buttons.
module button_conditioner #(
  parameter int               N_BTN      = 5,
  parameter int               DB_CYCLES  = 2000000,
  parameter int               RPT_DELAY  = 50000000,
  parameter int               RPT_PERIOD = 10000000,
  parameter logic [N_BTN-1:0] RPT_MASK   = 5'b00011
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_step,
  output logic             any_held
);

  localparam int DW   = $clog2(DB_CYCLES + 1);
  localparam int RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST     = DW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(RPT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(RPT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // Per-channel repeat FSM state, collected in one place for observation.
  rpt_state_e rpt_state [N_BTN];

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [1:0]    sync_q;
    logic [DW-1:0] db_cnt;
    logic [RW-1:0] rpt_cnt;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          step_q;
    rpt_state_e    state;
    logic          mismatch;
    logic          accept;
    logic          rise;
    logic          fall;

    assign mismatch = sync_q[1] ^ level_q;
    assign accept   = mismatch && (db_cnt == DB_LAST);
    // Strobes are decided from the edge that flips the level, so they line up with it.
    assign rise     = accept && !level_q;
    assign fall     = accept && level_q;

    always_ff @(posedge clk) begin
      if (CLR) begin
        sync_q    <= '0;
        db_cnt    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        step_q    <= 1'b0;
        rpt_cnt   <= '0;
        state     <= IDLE;
      end else begin
        sync_q    <= {sync_q[0], btn_raw[i]};
        press_q   <= rise;
        release_q <= fall;
        step_q    <= 1'b0;

        if (!mismatch) begin
          db_cnt <= '0;
        end else if (accept) begin
          db_cnt  <= '0;
          level_q <= ~level_q;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end

        // Release takes priority over a repeat that expires in the same cycle.
        if (fall) begin
          state   <= IDLE;
          rpt_cnt <= '0;
        end else begin
          case (state)
            IDLE: begin
              if (rise) begin
                step_q  <= 1'b1;
                rpt_cnt <= '0;
                state   <= DELAY;
              end
            end
            DELAY: begin
              if (RPT_MASK[i]) begin
                if (rpt_cnt == DELAY_LAST) begin
                  step_q  <= 1'b1;
                  rpt_cnt <= '0;
                  state   <= REPEAT;
                end else begin
                  rpt_cnt <= rpt_cnt + 1'b1;
                end
              end
            end
            REPEAT: begin
              if (rpt_cnt == PERIOD_LAST) begin
                step_q  <= 1'b1;
                rpt_cnt <= '0;
              end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_step[i]    = step_q;
    assign rpt_state[i]   = state;
  end

  assign any_held = |btn_level;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: expected strobe events (kind, channel, cycle) are
// queued as stimulus is driven and matched against DUT strobes each cycle.
module tb_button_conditioner;
  localparam int N  = 5;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int W  = 32;
  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_STEP    = 2;

  logic         clk = 1'b0;
  logic         CLR = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_step;
  logic         any_held;

  button_conditioner #(
    .N_BTN(N), .DB_CYCLES(DB), .RPT_DELAY(RD), .RPT_PERIOD(RP), .RPT_MASK(5'b00011)
  ) dut (
    .clk(clk), .CLR(CLR), .btn_raw(btn_raw), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .btn_step(btn_step),
    .any_held(any_held)
  );

  // clock / reset
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [W-1:0] mk_ev(input int kind, input int ch, input int unsigned c);
    logic [1:0]  k2;
    logic [2:0]  c3;
    logic [26:0] t27;
    k2  = kind[1:0];
    c3  = ch[2:0];
    t27 = c[26:0];
    return {k2, c3, t27};
  endfunction

  // scoreboard: every strobe bit must match the queue head for this cycle
  always @(posedge clk) begin
    logic [3*N-1:0] obs;
    logic [W-1:0]   got;
    logic [W-1:0]   exp;
    #1;
    while (exp_q.size() > 0 && exp_q[0][26:0] < cyc[26:0]) begin
      n_checks++;
      n_fail++;
      $display("FAIL missed_strobe: event %h not seen, now cycle %0d", exp_q[0], cyc);
      void'(exp_q.pop_front());
    end
    obs = {btn_step, btn_release, btn_press};
    for (int k = 0; k < 3; k++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (obs[k*N+ch]) begin
          got = mk_ev(k, ch, cyc);
          n_checks++;
          if (exp_q.size() == 0 || exp_q[0][26:0] != cyc[26:0]) begin
            n_fail++;
            $display("FAIL unexpected_strobe: got kind=%0d ch=%0d cycle=%0d, required none", k, ch, cyc);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              n_fail++;
              $display("FAIL strobe_event: got %h, required %h", got, exp);
            end
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    int unsigned c;
    CLR = 1'b1;
    btn_raw = '1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_checks++;
      if ({btn_level, btn_press, btn_release, btn_step, any_held} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got lvl=%b prs=%b rel=%b stp=%b held=%b, required all 0",
                 btn_level, btn_press, btn_release, btn_step, any_held);
      end
    end
    c = cyc;
    for (int ch = 0; ch < N; ch++) exp_q.push_back(mk_ev(K_PRESS, ch, c + 6));
    for (int ch = 0; ch < N; ch++) exp_q.push_back(mk_ev(K_STEP, ch, c + 6));
    CLR = 1'b0;
    tick(5);
    n_checks++;
    if (btn_level !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_early_level: got %b, required 00000", btn_level);
    end
    tick(1);
    n_checks++;
    if (btn_level !== 5'b11111 || any_held !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_accept_level: got lvl=%b held=%b, required 11111/1", btn_level, any_held);
    end
    tick(1);
    btn_raw = '0;
    for (int ch = 0; ch < N; ch++) exp_q.push_back(mk_ev(K_RELEASE, ch, cyc + 6));
    tick(10);
    n_checks++;
    if (btn_level !== '0 || any_held !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_end: got lvl=%b held=%b pending=%0d, required 0/0/0", btn_level, any_held, exp_q.size());
    end
  endtask

  task automatic test_bounce();
    int unsigned e;
    for (int i = 0; i < 4; i++) begin
      btn_raw[0] = ~i[0];
      tick(2);
    end
    btn_raw[0] = 1'b1;
    e = cyc;
    exp_q.push_back(mk_ev(K_PRESS, 0, e + 6));
    exp_q.push_back(mk_ev(K_STEP, 0, e + 6));
    tick(5);
    n_checks++;
    if (btn_level[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_early: got level0=%b, required 0", btn_level[0]);
    end
    tick(2);
    btn_raw[0] = 1'b0;
    exp_q.push_back(mk_ev(K_RELEASE, 0, cyc + 6));
    tick(10);
    n_checks++;
    if (exp_q.size() != 0 || btn_level !== '0) begin
      n_fail++;
      $display("FAIL bounce_end: got pending=%0d lvl=%b, required 0/00000", exp_q.size(), btn_level);
    end
  endtask

  task automatic test_auto_repeat();
    int unsigned t;
    btn_raw[0] = 1'b1;
    t = cyc + 6;
    exp_q.push_back(mk_ev(K_PRESS, 0, t));
    exp_q.push_back(mk_ev(K_STEP, 0, t));
    for (int unsigned s = t + RD; s < t + 36; s += RP) exp_q.push_back(mk_ev(K_STEP, 0, s));
    exp_q.push_back(mk_ev(K_RELEASE, 0, t + 36));
    tick(6 + 15);
    n_checks++;
    if (btn_level[0] !== 1'b1 || any_held !== 1'b1) begin
      n_fail++;
      $display("FAIL repeat_held_level: got lvl0=%b held=%b, required 1/1", btn_level[0], any_held);
    end
    tick(15);
    btn_raw[0] = 1'b0;
    tick(14);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL repeat_end: got pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_masked();
    int unsigned t;
    btn_raw[2] = 1'b1;
    t = cyc + 6;
    exp_q.push_back(mk_ev(K_PRESS, 2, t));
    exp_q.push_back(mk_ev(K_STEP, 2, t));
    exp_q.push_back(mk_ev(K_RELEASE, 2, t + 46));
    tick(6 + 40);
    btn_raw[2] = 1'b0;
    tick(12);
    n_checks++;
    if (exp_q.size() != 0 || btn_level[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL masked_end: got pending=%0d lvl2=%b, required 0/0", exp_q.size(), btn_level[2]);
    end
  endtask

  task automatic test_collision();
    int unsigned t;
    btn_raw[0] = 1'b1;
    t = cyc + 6;
    exp_q.push_back(mk_ev(K_PRESS, 0, t));
    exp_q.push_back(mk_ev(K_STEP, 0, t));
    exp_q.push_back(mk_ev(K_STEP, 0, t + 10));
    exp_q.push_back(mk_ev(K_STEP, 0, t + 13));
    exp_q.push_back(mk_ev(K_RELEASE, 0, t + 16));
    tick(6 + 10);
    btn_raw[0] = 1'b0;
    tick(6);
    n_checks++;
    if (btn_release[0] !== 1'b1 || btn_step[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_cycle: got rel0=%b step0=%b, required 1/0", btn_release[0], btn_step[0]);
    end
    tick(20);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL collision_end: got pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_hold();
    int unsigned t;
    int unsigned r;
    btn_raw[1] = 1'b1;
    t = cyc + 6;
    exp_q.push_back(mk_ev(K_PRESS, 1, t));
    exp_q.push_back(mk_ev(K_STEP, 1, t));
    exp_q.push_back(mk_ev(K_STEP, 1, t + 10));
    exp_q.push_back(mk_ev(K_STEP, 1, t + 13));
    tick(20);
    r = cyc;
    CLR = 1'b1;
    tick(1);
    n_checks++;
    if ({btn_level, btn_press, btn_release, btn_step, any_held} !== '0) begin
      n_fail++;
      $display("FAIL midhold_reset_outputs: got lvl=%b stp=%b held=%b, required 0", btn_level, btn_step, any_held);
    end
    CLR = 1'b0;
    exp_q.push_back(mk_ev(K_PRESS, 1, r + 7));
    exp_q.push_back(mk_ev(K_STEP, 1, r + 7));
    exp_q.push_back(mk_ev(K_STEP, 1, r + 17));
    exp_q.push_back(mk_ev(K_STEP, 1, r + 20));
    exp_q.push_back(mk_ev(K_STEP, 1, r + 23));
    exp_q.push_back(mk_ev(K_RELEASE, 1, r + 24));
    tick(17);
    btn_raw[1] = 1'b0;
    tick(12);
    n_checks++;
    if (exp_q.size() != 0 || btn_level !== '0) begin
      n_fail++;
      $display("FAIL midhold_end: got pending=%0d lvl=%b, required 0/00000", exp_q.size(), btn_level);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_bounce();
    test_auto_repeat();
    test_masked();
    test_collision();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
